// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer and the arbiters built on it.
// Arbitration mode is selected by the STREAM_MUX_RR_EN macro (round-robin when defined).
package stream_mux_pkg;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;

    // Grant vector sized for the widest supported arbiter in the core
    typedef logic [NUM_IN_MAX-1:0] grant_vec_t;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Single-grant arbiter: round-robin from ptr when STREAM_MUX_RR_EN is defined,
// otherwise fixed priority where the lowest requesting index wins.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SELW   = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
`ifdef STREAM_MUX_RR_EN
    input  logic [SELW-1:0]   ptr,
`endif
    output logic [NUM_IN-1:0] grant,
    output logic [SELW-1:0]   grant_idx,
    output logic              any_req
);

    int               cand_s;
    logic [SELW-1:0]  cand_idx_s;
    logic             hit_s;
    logic             found_s;

    // Walk the channels in search order and grant the first requester found
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
`ifdef STREAM_MUX_RR_EN
            cand_s = int'(ptr) + k;
            cand_s = (cand_s >= NUM_IN) ? (cand_s - NUM_IN) : cand_s;
`else
            cand_s = k;
`endif
            cand_idx_s        = SELW'(cand_s);
            hit_s             = !found_s && req[cand_idx_s];
            grant[cand_idx_s] = hit_s;
            grant_idx         = hit_s ? cand_idx_s : grant_idx;
            found_s           = found_s || hit_s;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream mux with a one-entry output register and single-grant arbitration.
// Define STREAM_MUX_RR_EN for round-robin; undefined gives fixed lowest-index priority.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NUM_IN    = 4,
    localparam int SELW     = sel_width(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    output logic [DATAWIDTH-1:0]        out_data,
    output logic [SELW-1:0]             out_sel,
    input  logic                        out_ready
);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("stream_mux_rr: NUM_IN out of supported range");
    end

    logic [NUM_IN-1:0] grant_s;
    logic [SELW-1:0]   grant_idx_s;
    logic              any_req_s;
    logic              load_en_s;
    logic              accept_s;

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0]   ptr_r;
`endif

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SELW   (SELW)
    ) u_arb (
        .req       (in_valid),
`ifdef STREAM_MUX_RR_EN
        .ptr       (ptr_r),
`endif
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_req   (any_req_s)
    );

    // The register can take a beat when empty or when its beat leaves this cycle
    assign load_en_s = !out_valid || out_ready;
    assign accept_s  = load_en_s && any_req_s;
    assign in_ready  = rst ? '0 : (grant_s & {NUM_IN{load_en_s}});

    // Output register: load the granted beat, or go empty on a plain drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx_s)*DATAWIDTH +: DATAWIDTH];
            out_sel   <= grant_idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Next search starts just past the last accepted channel, wrapping at NUM_IN-1
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (int'(grant_idx_s) == NUM_IN - 1) ? '0 : (grant_idx_s + SELW'(1));
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench: behavioural queue-free reference for a 4-input mux plus
// literal scenario checks, and a 3-input instance for the non-power-of-two wrap.
module tb_stream_mux_rr;

`ifdef STREAM_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [2:0]   in_valid3;
    logic [23:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [7:0]   out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.DATAWIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    stream_mux_rr #(.DATAWIDTH(8), .NUM_IN(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_sel(out_sel3), .out_ready(out_ready3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = first requester met when counting upward from start, modulo 4
    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Reference state: what the output register and pointer must hold
    bit          live = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;

    always @(negedge clk) begin
        int          g;
        logic [3:0]  exp_rdy;
        bit          le;
        le = !m_valid || out_ready;
        g  = pick(in_valid, RR ? m_ptr : 0);
        if (live) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("out_data", out_data, m_data);
            chk("out_sel", {30'd0, out_sel}, 32'(m_sel));
            exp_rdy = 4'd0;
            if (!rst && le && g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            if (out_valid3) chk("sel3_range", {31'd0, (out_sel3 < 2'd3)}, 32'd1);
        end
        if (rst) begin
            m_valid = 1'b0; m_data = 32'd0; m_sel = 0; m_ptr = 0;
        end else if (le && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*32 +: 32];
            m_sel   = g;
            m_ptr   = (g + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        live = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          exp4[6];
        int          exp3[6];
        int          exps[3];
        logic [31:0] held;
        logic [3:0]  rdy_q;
        logic [3:0]  hold;

        for (int i = 0; i < 6; i++) begin
            exp4[i] = RR ? (i % 4) : 0;
            exp3[i] = RR ? (i % 3) : 0;
        end
        exps[0] = RR ? 3 : 1;
        exps[1] = 1;
        exps[2] = RR ? 3 : 1;
        held = RR ? 32'hA2 : 32'hA0;

        rst = 1'b1;
        in_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'hB0 + 8'(i);

        step(); step(); step();
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_sel", {30'd0, out_sel}, 32'd0);
        chk("rst_ready", {28'd0, in_ready}, 32'd0);
        chk("rst_ready3", {29'd0, in_ready3}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", {28'd0, in_ready}, 32'h1);
        chk("first_grant3", {29'd0, in_ready3}, 32'h1);

        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("seq_sel", {30'd0, out_sel}, 32'(exp4[i]));
            chk("seq_data", out_data, 32'hA0 + 32'(exp4[i]));
            chk("seq_sel3", {30'd0, out_sel3}, 32'(exp3[i]));
            chk("seq_data3", {24'd0, out_data3}, 32'hB0 + 32'(exp3[i]));
        end

        step();
        in_valid = 4'b0100;
        in_data[2*32 +: 32] = 32'hC2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", out_data, held);
            chk("bp_ready", {28'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {28'd0, in_ready}, 32'h4);
        step();
        @(negedge clk);
        chk("bp_next_data", out_data, 32'hC2);
        chk("bp_next_sel", {30'd0, out_sel}, 32'd2);

        step();
        in_valid = 4'b0010;
        step();
        in_valid = 4'b1010;
        @(negedge clk);
        chk("sparse_pre", {30'd0, out_sel}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("sparse_sel", {30'd0, out_sel}, 32'(exps[i]));
            chk("sparse_data", out_data, 32'hA0 + 32'(exps[i]));
        end

        // Random traffic; a channel waiting for ready keeps its valid and payload
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rdy_q = in_ready;
            hold = in_valid & ~rdy_q & {4{!rst}};
            step();
            rst = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!hold[i]) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    in_data[i*32 +: 32] = $urandom;
                end
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Registered N-input stream multiplexer with valid/ready handshake and arbitration. It is the parametrised successor to the plain 2:1 datapath mux. It adds channel count, per-input flow control, fair arbitration and a one-entry output register. It sits wherever several producers share one consumer in the core, such as writeback-source merging or the memory-request port shared by fetch and load/store.

## Interface
Parameters:
- DATAWIDTH, 32, payload width per channel
- NUM_IN, 4, number of input channels; legal range 2..16

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  NUM_IN  per-channel valid
- in_data  input  NUM_IN*DATAWIDTH  packed payloads; channel i occupies bits [i*DATAWIDTH +: DATAWIDTH]
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  DATAWIDTH  registered payload
- out_sel  output  SELW  index of the channel that supplied out_data; SELW = clog2(NUM_IN)
- out_ready  input  1  consumer accepts the beat

## Operation
- Transfer rule: a beat moves when valid and ready are both high in the same cycle, on both sides.
- load_en = !out_valid || out_ready. The output register may load whenever it is empty or is being drained this cycle.
- Arbitration:
  - Each cycle, the arbiter picks at most one requesting channel (in_valid[i]=1) as grant.
  - in_ready = grant & {NUM_IN{load_en}}, so in_ready is combinational from in_valid, out_valid, out_ready and the pointer.
- On load (load_en and any in_valid):
  - out_data <= in_data of the granted channel
  - out_sel <= granted index
  - out_valid <= 1
- On drain without load (out_ready && out_valid, no request): out_valid <= 0. out_data and out_sel hold their values.
- When out_valid=0 and out_ready=0, no state changes except loads.
- Drain and load in the same cycle are allowed. This gives full throughput: one beat per cycle.
- A channel holding in_valid without receiving in_ready must keep in_data stable. The block does not check this.
- Round-robin pointer ptr (SELW bits):
  - Search starts at ptr and wraps modulo NUM_IN.
  - On each accepted input transfer, ptr <= (granted index + 1) mod NUM_IN.
  - Wrap from NUM_IN-1 to 0 also applies when NUM_IN is not a power of two.
- No internal FSM beyond the out_valid flag and ptr. The output register is either EMPTY (out_valid=0) or FULL (out_valid=1).

## Timing
- Latency: an input accepted in cycle t is visible on out_* in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset values (applied at the clk edge while rst=1):
  - out_valid=0, out_data=0, out_sel=0, ptr=0
  - in_ready evaluates to 0 during reset.
- Reset mid-operation: any beat held in the output register is discarded. Inputs asserted during the reset cycle are not accepted.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready=0 and out_* hold.
- No combinational path from in_valid/in_data to out_*. in_ready does depend combinationally on out_ready.

## Configuration
- Macro: STREAM_MUX_RR_EN
- Defined: round-robin arbitration as described above. ptr is instantiated.
- Undefined: fixed priority; the lowest-index requesting channel wins. ptr is removed and out_sel behaviour is unchanged.
- Interface, latency and throughput are identical in both builds.

## Structure
- Package stream_mux_pkg holds:
  - function sel_width(n), returning clog2(n)
  - localparams for the NUM_IN legal bounds
  - a typedef for the packed grant vector, reused by other arbiters in the core
- Sub-module rr_arbiter (requests, ptr -> one-hot grant + index) holds the arbitration logic, including the compile-time fixed-priority variant.
- The top level holds the output register, ptr update and the payload mux.

## Test plan
- Reset: hold rst=1 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0; first grant after release goes to channel 0.
- Round-robin: NUM_IN=4, all valid continuously, out_ready=1, in_data[i]=32'hA0+i -> out_sel sequence 0,1,2,3,0,1; one beat per cycle after the 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles with channel 2 valid -> out_valid=1, out_data stable, in_ready=0; on out_ready=1, the next beat loads the same cycle the held beat drains.
- Sparse requests: only channels 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3.
- Fixed priority (STREAM_MUX_RR_EN undefined): channels 0 and 2 continuously valid -> channel 0 always granted; channel 2 starves.
- Non-power-of-two: NUM_IN=3, all valid -> out_sel 0,1,2,0, with no index 3 ever produced.
